bank_read_sched: RTL and testbench
==================================

BANK_READ_SCHED -- requirements
Module: bank_read_sched

Interface
REQ-001 Parameter BANKBITS, default 5, bank-select field width; bank = addr[WORDBITS +: BANKBITS].
REQ-002 Parameter WORDBITS, default 10, word-in-bank field width.
REQ-003 Parameter STARVE, default 4, consecutive-denial count that promotes a requester to top priority (range 1..15).
REQ-004 Parameter READLAT, default 2, memory read latency in cycles from mem_en to data valid (range 1..8).
REQ-005 A = BANKBITS+WORDBITS is the address width.
REQ-006 Clocking is decided: one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 hold  input  1  stall; while 1 no request is acknowledged.
REQ-010 i_req / d_req / c_req  input  1 each  read request from the input, data and coefficient requesters.
REQ-011 i_addr / d_addr / c_addr  input  A each  request address, valid while the matching _req is 1.
REQ-012 i_ack / d_ack / c_ack  output  1 each  combinational; request accepted this cycle.
REQ-013 mem_en  output  3  registered read enable per port (bit0 i, bit1 d, bit2 c).
REQ-014 mem_addr_i / mem_addr_d / mem_addr_c  output  A each  registered read address per port.
REQ-015 rvalid  output  3  read data valid per port (same bit order as mem_en).
REQ-016 busy  output  1  1 while any mem_en or in-flight rvalid pipeline bit is set.

Function
REQ-017 Conflict: two requests conflict when both _req=1 and their bank fields are equal.
REQ-018 Base priority SHALL be i > d > c.
REQ-019 A requester whose wait counter equals STARVE SHALL be promoted above all others; with several promoted, the lowest bit index wins, and the rest keep base order.
REQ-020 Grant walk: walk requesters in priority order; ack a requester iff _req=1, hold=0, and it conflicts with no requester already acked this cycle.
REQ-021 The highest-priority requesting port is always acked when hold=0 (no deadlock).
REQ-022 Wait counter per port: +1 on req & ~ack & ~hold, saturating at STARVE; cleared on ack or ~req; unchanged while hold=1 and req=1.
REQ-023 Requesters SHALL hold _req and _addr stable until acked; the block does not buffer unacked requests.
REQ-024 On the cycle after an ack: mem_en bit = 1 and mem_addr_x = the acked address; otherwise mem_en bit = 0 and mem_addr_x holds its last value.
REQ-025 rvalid bit SHALL assert exactly READLAT cycles after the matching mem_en bit, one cycle per ack, in order.
REQ-026 Throughput: each port accepts one request per cycle; back-to-back acks yield back-to-back rvalid.
REQ-027 Total ack-to-rvalid latency = 1 + READLAT cycles.
REQ-028 hold does not stall the mem_en or rvalid pipelines; in-flight reads complete.

Reset
REQ-029 rst=1 SHALL immediately clear mem_en, mem_addr_*, rvalid, busy, all wait counters and the delay pipeline to 0.
REQ-030 Acks are 0 while rst=1; requests pending across reset are re-arbitrated from base priority afterwards.
REQ-031 Reset mid-flight discards in-flight reads; no rvalid for them after reset.

Structure
REQ-032 A shared package holds BANKBITS/WORDBITS defaults, port index constants (PORT_I=0, PORT_D=1, PORT_C=2) and the bank-field extraction width.
REQ-033 One sub-module, rd_delay_line (parameter DEPTH, width 3, async active-high reset), implements the mem_en-to-rvalid shift register.

Verification
REQ-034 i,d,c banks 1,2,3, hold=0 at cycle 0 -> all acks=1 at cycle 0, mem_en=3'b111 at cycle 1, rvalid=3'b111 at cycle 3.
REQ-035 i and d persistently bank 5, STARVE=4 -> d denied cycles 0..3 with i acked; cycle 4 d acked, i denied; cycle 5 i acked again.
REQ-036 i bank 2, d and c bank 7 -> i_ack=1, d_ack=1, c_ack=0; c wait counter = 1 next cycle.
REQ-037 hold=1 for 3 cycles with all three requesting, banks 1/2/3 -> no acks, counters stay 0; first cycle after hold=0 -> all three acked.
REQ-038 rst pulsed at cycle 2 after acks at cycles 0 and 1 -> mem_en, rvalid and busy = 0 at once; no rvalid in the following 4 cycles without new requests.

Source files
------------

// File: rtl/bank_read_sched_pkg.sv
// Shared constants for the banked read scheduler: field widths, port indices
// and the starvation counter width.
package bank_read_sched_pkg;

  localparam int BANKBITS_DEF = 5;
  localparam int WORDBITS_DEF = 10;
  localparam int ADDR_W_DEF   = BANKBITS_DEF + WORDBITS_DEF;

  // Width of the bank-select field carved out of an address
  localparam int BANK_W_DEF   = BANKBITS_DEF;

  localparam int NPORTS = 3;
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;
  localparam int PORT_C = 2;

  // Wait counters hold values up to STARVE (at most 15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/bank_read_sched_if.sv
// Request/ack and memory-side bus of the banked read scheduler.
// master = requester/memory side, slave = the scheduler itself.
interface bank_read_sched_if import bank_read_sched_pkg::*; #(
  parameter int A = ADDR_W_DEF
) ();

  logic         hold;
  logic         i_req;
  logic         d_req;
  logic         c_req;
  logic [A-1:0] i_addr;
  logic [A-1:0] d_addr;
  logic [A-1:0] c_addr;
  logic         i_ack;
  logic         d_ack;
  logic         c_ack;
  logic [2:0]   mem_en;
  logic [A-1:0] mem_addr_i;
  logic [A-1:0] mem_addr_d;
  logic [A-1:0] mem_addr_c;
  logic [2:0]   rvalid;
  logic         busy;

  modport master (
    output hold, i_req, d_req, c_req, i_addr, d_addr, c_addr,
    input  i_ack, d_ack, c_ack, mem_en, mem_addr_i, mem_addr_d, mem_addr_c,
    input  rvalid, busy
  );

  modport slave (
    input  hold, i_req, d_req, c_req, i_addr, d_addr, c_addr,
    output i_ack, d_ack, c_ack, mem_en, mem_addr_i, mem_addr_d, mem_addr_c,
    output rvalid, busy
  );

endinterface

// File: rtl/bank_read_sched_rd_delay_line.sv
// Fixed-depth shift register carrying per-port read enables forward to the
// cycle their data comes back from memory.
module rd_delay_line import bank_read_sched_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] din,
  output logic [NPORTS-1:0] dout,
  output logic              pending
);

  logic [DEPTH-1:0][NPORTS-1:0] vld_p;

  // Shift the enables one stage per clock; reset drops everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign dout    = vld_p[DEPTH-1];
  assign pending = |vld_p;

endmodule

// File: rtl/bank_read_sched.sv
// Three-port banked read scheduler. Requests whose bank fields collide are
// serialised by a priority walk (i > d > c, starving ports promoted); acked
// reads are registered onto the memory ports and their data-valid strobes
// are delayed by the memory read latency.
module bank_read_sched import bank_read_sched_pkg::*; #(
  parameter int BANKBITS = BANKBITS_DEF,
  parameter int WORDBITS = WORDBITS_DEF,
  parameter int STARVE   = 4,
  parameter int READLAT  = 2
) (
  input  logic clk,
  input  logic rst,
  bank_read_sched_if.slave bus
);

  localparam int A = BANKBITS + WORDBITS;
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE);

  logic [NPORTS-1:0]                req;
  logic [NPORTS-1:0][A-1:0]         addr;
  logic [NPORTS-1:0][BANKBITS-1:0]  bank;
  logic [NPORTS-1:0]                promoted;
  logic [NPORTS-1:0]                ack_p0;
  logic                             conflict;
  logic [NPORTS-1:0][CNT_W-1:0]     wait_cnt;
  logic [NPORTS-1:0]                mem_en_p1;
  logic [NPORTS-1:0][A-1:0]         mem_addr_p1;
  logic [NPORTS-1:0]                rvalid_pn;
  logic                             pipe_pending;

  assign req[PORT_I]  = bus.i_req;
  assign req[PORT_D]  = bus.d_req;
  assign req[PORT_C]  = bus.c_req;
  assign addr[PORT_I] = bus.i_addr;
  assign addr[PORT_D] = bus.d_addr;
  assign addr[PORT_C] = bus.c_addr;

  // Bank field of each request and starvation promotion flags
  always_comb begin
    bank     = '0;
    promoted = '0;
    for (int p = 0; p < NPORTS; p++) begin
      bank[p]     = addr[p][WORDBITS +: BANKBITS];
      promoted[p] = (wait_cnt[p] == STARVE_C);
    end
  end

  // Grant walk: promoted ports first, then the rest, each group in index
  // order (index order is also base priority). The first requester visited
  // can never conflict, so someone is always served when not held.
  always_comb begin
    ack_p0   = '0;
    conflict = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (((pass == 0) == promoted[p]) && req[p] && !bus.hold && !rst) begin
          conflict = 1'b0;
          for (int q = 0; q < NPORTS; q++) begin
            if (ack_p0[q] && (bank[q] == bank[p])) conflict = 1'b1;
          end
          if (!conflict) ack_p0[p] = 1'b1;
        end
      end
    end
  end

  assign bus.i_ack = ack_p0[PORT_I];
  assign bus.d_ack = ack_p0[PORT_D];
  assign bus.c_ack = ack_p0[PORT_C];

  // Per-port wait counters: count denied cycles, freeze under hold, saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (!req[p] || ack_p0[p]) begin
          wait_cnt[p] <= '0;
        end else if (!bus.hold && (wait_cnt[p] != STARVE_C)) begin
          wait_cnt[p] <= wait_cnt[p] + 1'b1;
        end
      end
    end
  end

  // ---- stage p0 -> p1: register acked reads onto the memory ports ----
  // Address registers keep their last value when a port is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_p1   <= '0;
      mem_addr_p1 <= '0;
    end else begin
      mem_en_p1 <= ack_p0;
      for (int p = 0; p < NPORTS; p++) begin
        if (ack_p0[p]) mem_addr_p1[p] <= addr[p];
      end
    end
  end

  // ---- stage p1 -> p1+READLAT: memory latency ----
  rd_delay_line #(
    .DEPTH (READLAT)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .din     (mem_en_p1),
    .dout    (rvalid_pn),
    .pending (pipe_pending)
  );

  assign bus.mem_en     = mem_en_p1;
  assign bus.mem_addr_i = mem_addr_p1[PORT_I];
  assign bus.mem_addr_d = mem_addr_p1[PORT_D];
  assign bus.mem_addr_c = mem_addr_p1[PORT_C];
  assign bus.rvalid     = rvalid_pn;
  assign bus.busy       = (|mem_en_p1) | pipe_pending;

endmodule

// File: tb/tb_bank_read_sched.sv
// Scoreboard bench for bank_read_sched: the driver pushes expected acks,
// memory enables/addresses and rvalid cycles; a negedge monitor pops them.
module tb_bank_read_sched;
  import bank_read_sched_pkg::*;

  localparam int A       = 15;
  localparam int READLAT = 2;

  typedef struct { int cyc; logic [2:0] mask; } ack_exp_t;
  typedef struct { int cyc; logic [A-1:0] addr; } mem_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ack_exp_t ack_q[$];
  mem_exp_t mem_q[3][$];
  int       rv_q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_read_sched_if #(.A(A)) bus();

  bank_read_sched #(
    .BANKBITS (5),
    .WORDBITS (10),
    .STARVE   (4),
    .READLAT  (READLAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [A-1:0] mk(input int bnk, input int word);
    return A'((bnk << 10) | word);
  endfunction

  function automatic logic [A-1:0] mem_addr_of(input int p);
    case (p)
      0:       return bus.mem_addr_i;
      1:       return bus.mem_addr_d;
      default: return bus.mem_addr_c;
    endcase
  endfunction

  // One cycle of stimulus: drive inputs, queue expected responses, advance
  task automatic drive(input bit ir, input int ib, input bit dr, input int db,
                       input bit cr, input int cb, input bit h, input logic [2:0] exp);
    logic [A-1:0] a [3];
    ack_exp_t ae;
    mem_exp_t me;
    a[0] = mk(ib, 17);
    a[1] = mk(db, 300);
    a[2] = mk(cb, 1000);
    bus.i_req = ir; bus.i_addr = a[0];
    bus.d_req = dr; bus.d_addr = a[1];
    bus.c_req = cr; bus.c_addr = a[2];
    bus.hold  = h;
    ae.cyc = cyc; ae.mask = exp;
    ack_q.push_back(ae);
    for (int p = 0; p < 3; p++) begin
      if (exp[p]) begin
        me.cyc = cyc + 1; me.addr = a[p];
        mem_q[p].push_back(me);
        rv_q[p].push_back(cyc + 1 + READLAT);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    ack_exp_t ae;
    mem_exp_t me;
    int       rc;
    if (!rst) begin
      if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
        ae = ack_q.pop_front();
        check("ack_cycle", cyc, ae.cyc);
        check("acks", {bus.c_ack, bus.d_ack, bus.i_ack}, ae.mask);
      end
      for (int p = 0; p < 3; p++) begin
        while (mem_q[p].size() > 0 && mem_q[p][0].cyc < cyc) begin
          me = mem_q[p].pop_front();
          check($sformatf("mem_en_missing_p%0d", p), 0, 1);
        end
        if (bus.mem_en[p]) begin
          if (mem_q[p].size() == 0) begin
            check($sformatf("mem_en_unexpected_p%0d", p), 1, 0);
          end else begin
            me = mem_q[p].pop_front();
            check($sformatf("mem_en_cycle_p%0d", p), cyc, me.cyc);
            check($sformatf("mem_addr_p%0d", p), 32'(mem_addr_of(p)), 32'(me.addr));
          end
        end
        while (rv_q[p].size() > 0 && rv_q[p][0] < cyc) begin
          rc = rv_q[p].pop_front();
          check($sformatf("rvalid_missing_p%0d", p), 0, 1);
        end
        if (bus.rvalid[p]) begin
          if (rv_q[p].size() == 0) begin
            check($sformatf("rvalid_unexpected_p%0d", p), 1, 0);
          end else begin
            rc = rv_q[p].pop_front();
            check($sformatf("rvalid_cycle_p%0d", p), cyc, rc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hold = 0;
    bus.i_req = 0; bus.d_req = 0; bus.c_req = 0;
    bus.i_addr = '0; bus.d_addr = '0; bus.c_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with requests pending: acks blocked, outputs cleared
    bus.i_req = 1; bus.d_req = 1; bus.c_req = 1;
    bus.i_addr = mk(1, 0); bus.d_addr = mk(2, 0); bus.c_addr = mk(3, 0);
    #1;
    check("rst_acks", {bus.c_ack, bus.d_ack, bus.i_ack}, 3'b000);
    check("rst_mem_en", bus.mem_en, 3'b000);
    check("rst_rvalid", bus.rvalid, 3'b000);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_addr_i", 32'(bus.mem_addr_i), 0);
    bus.i_req = 0; bus.d_req = 0; bus.c_req = 0;
    rst = 0;
    @(posedge clk);
    #1;

    // Distinct banks: all acked, mem_en next cycle, rvalid READLAT later
    drive(1, 1, 1, 2, 1, 3, 0, 3'b111);
    check("busy_after_ack", bus.busy, 1);
    idle(4);
    check("busy_drained", bus.busy, 0);

    // i and d fight over bank 5: d starves for STARVE cycles, then wins once
    for (int k = 0; k < 4; k++) drive(1, 5, 1, 5, 0, 0, 0, 3'b001);
    check("d_cnt_at_starve", 32'(dut.wait_cnt[PORT_D]), 4);
    drive(1, 5, 1, 5, 0, 0, 0, 3'b010);
    check("i_cnt_after_promo", 32'(dut.wait_cnt[PORT_I]), 1);
    check("d_cnt_cleared", 32'(dut.wait_cnt[PORT_D]), 0);
    drive(1, 5, 1, 5, 0, 0, 0, 3'b001);
    idle(1);

    // d and c share bank 7, i elsewhere: c loses to d
    drive(1, 2, 1, 7, 1, 7, 0, 3'b011);
    check("c_cnt_one", 32'(dut.wait_cnt[PORT_C]), 1);
    drive(0, 0, 0, 0, 1, 7, 0, 3'b100);
    idle(1);

    // Hold blocks every ack and freezes counters
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 2, 1, 3, 1, 3'b000);
      check("hold_cnts", 32'(dut.wait_cnt), 0);
    end
    drive(1, 1, 1, 2, 1, 3, 0, 3'b111);
    idle(4);

    // Reset mid-flight discards in-flight reads
    drive(1, 1, 0, 0, 0, 0, 0, 3'b001);
    drive(0, 0, 1, 2, 0, 0, 0, 3'b010);
    bus.i_req = 1; bus.i_addr = mk(4, 0);
    bus.d_req = 0; bus.c_req = 0;
    #1;
    rst = 1;
    #1;
    check("midrst_mem_en", bus.mem_en, 3'b000);
    check("midrst_rvalid", bus.rvalid, 3'b000);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ack", bus.i_ack, 0);
    for (int p = 0; p < 3; p++) begin
      mem_q[p].delete();
      rv_q[p].delete();
    end
    bus.i_req = 0;
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rvalid_after_rst", bus.rvalid, 3'b000);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    check("ack_q_empty", ack_q.size(), 0);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("mem_q_empty_p%0d", p), mem_q[p].size(), 0);
      check($sformatf("rv_q_empty_p%0d", p), rv_q[p].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
